// File: rtl/inst_encode_pkg.sv
// Shared field widths, MIPS opcode/funct constants and FSM encodings for the
// instruction encoder and anything (e.g. a scoreboard) that reuses inst_pack.
package inst_encode_pkg;

    localparam int W_CPU     = 32;
    localparam int W_REG     = 5;
    localparam int W_OP      = 6;
    localparam int W_FUNCT   = 6;
    localparam int FLD_SHAMT = 5;
    localparam int W_IMM     = 16;
    localparam int W_JADDR   = 26;

    localparam logic [W_OP-1:0] OP_ZERO  = 6'h00;
    localparam logic [W_OP-1:0] OP_J     = 6'h02;
    localparam logic [W_OP-1:0] OP_JAL   = 6'h03;
    localparam logic [W_OP-1:0] OP_BEQ   = 6'h04;
    localparam logic [W_OP-1:0] OP_BNE   = 6'h05;
    localparam logic [W_OP-1:0] OP_ADDI  = 6'h08;
    localparam logic [W_OP-1:0] OP_ADDIU = 6'h09;
    localparam logic [W_OP-1:0] OP_SLTI  = 6'h0A;
    localparam logic [W_OP-1:0] OP_SLTIU = 6'h0B;
    localparam logic [W_OP-1:0] OP_ANDI  = 6'h0C;
    localparam logic [W_OP-1:0] OP_ORI   = 6'h0D;
    localparam logic [W_OP-1:0] OP_XORI  = 6'h0E;
    localparam logic [W_OP-1:0] OP_LUI   = 6'h0F;
    localparam logic [W_OP-1:0] OP_LW    = 6'h23;
    localparam logic [W_OP-1:0] OP_SW    = 6'h2B;

    localparam logic [W_FUNCT-1:0] F_SLL    = 6'h00;
    localparam logic [W_FUNCT-1:0] F_SRL    = 6'h02;
    localparam logic [W_FUNCT-1:0] F_SYSCAL = 6'h0C;
    localparam logic [W_FUNCT-1:0] F_ADD    = 6'h20;
    localparam logic [W_FUNCT-1:0] F_ADDU   = 6'h21;
    localparam logic [W_FUNCT-1:0] F_SUB    = 6'h22;
    localparam logic [W_FUNCT-1:0] F_SUBU   = 6'h23;
    localparam logic [W_FUNCT-1:0] F_AND    = 6'h24;
    localparam logic [W_FUNCT-1:0] F_OR     = 6'h25;
    localparam logic [W_FUNCT-1:0] F_NOR    = 6'h27;
    localparam logic [W_FUNCT-1:0] F_SLT    = 6'h2A;
    localparam logic [W_FUNCT-1:0] F_SLTU   = 6'h2B;

    typedef enum logic [1:0] {
        ENC_IDLE  = 2'd0,
        ENC_LOAD  = 2'd1,
        ENC_DRAIN = 2'd2,
        ENC_DONE  = 2'd3
    } enc_state_t;

    function automatic logic funct_legal(input logic [W_FUNCT-1:0] f);
        case (f)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_NOR,
            F_SLT, F_SLTU, F_SLL, F_SRL, F_SYSCAL: funct_legal = 1'b1;
            default:                              funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/inst_encode_pack.sv
// Purely combinational field packer: decoded fields in, 32-bit MIPS word and
// an illegal-encoding flag out. Illegal bundles produce an all-zero word.
module inst_pack
    import inst_encode_pkg::*;
(
    input  logic [W_OP-1:0]      op,
    input  logic [W_FUNCT-1:0]   funct,
    input  logic [W_REG-1:0]     rs,
    input  logic [W_REG-1:0]     rt,
    input  logic [W_REG-1:0]     rd,
    input  logic [FLD_SHAMT-1:0] shamt,
    input  logic [W_IMM-1:0]     imm,
    input  logic [W_JADDR-1:0]   jaddr,
    output logic [W_CPU-1:0]     word,
    output logic                 illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_ZERO: begin
                if (!funct_legal(funct)) begin
                    illegal = 1'b1;
                end else if (funct == F_SYSCAL) begin
                    word = {26'd0, funct};
                end else if (funct == F_SLL || funct == F_SRL) begin
                    word = {OP_ZERO, 5'd0, rt, rd, shamt, funct};
                end else begin
                    word = {OP_ZERO, rs, rt, rd, 5'd0, funct};
                end
            end
            OP_J, OP_JAL: word = {op, jaddr};
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
            OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE: word = {op, rs, rt, imm};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encode.sv
// Program loader: packs field bundles into MIPS words and streams them into
// instruction memory through a single backpressured output register.
module inst_encode
    import inst_encode_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [W_CPU-1:0]     base_addr,
    input  logic [15:0]          count,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_OP-1:0]      in_op,
    input  logic [W_FUNCT-1:0]   in_funct,
    input  logic [W_REG-1:0]     in_rs,
    input  logic [W_REG-1:0]     in_rt,
    input  logic [W_REG-1:0]     in_rd,
    input  logic [FLD_SHAMT-1:0] in_shamt,
    input  logic [W_IMM-1:0]     in_imm,
    input  logic [W_JADDR-1:0]   in_jaddr,
    output logic                 mem_wen,
    input  logic                 mem_ready,
    output logic [W_CPU-1:0]     mem_addr,
    output logic [W_CPU-1:0]     mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          n_written,
    output enc_state_t           state
);

    // Handshakes: a bundle moves when in_valid && in_ready; a write completes
    // when mem_wen && mem_ready, and mem_wen/addr/wdata hold until then.
    enc_state_t        state_next;
    logic [15:0]       remaining;
    logic [W_CPU-1:0]  wptr;
    logic [W_CPU-1:0]  word;
    logic              illegal;
    logic              accept;
    logic              wr_done;
    logic              reg_free;
    logic              start_load;

    inst_pack u_pack (
        .op      (in_op),
        .funct   (in_funct),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .jaddr   (in_jaddr),
        .word    (word),
        .illegal (illegal)
    );

    assign reg_free   = !mem_wen || mem_ready;
    assign in_ready   = (state == ENC_LOAD) && (remaining != 16'd0) && reg_free;
    assign accept     = in_valid && in_ready;
    assign wr_done    = mem_wen && mem_ready;
    assign start_load = (state == ENC_IDLE) && start;
    assign busy       = (state == ENC_LOAD) || (state == ENC_DRAIN);
    assign done       = (state == ENC_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ENC_IDLE:  if (start) state_next = ENC_LOAD;
            ENC_LOAD: begin
                if (remaining == 16'd0) begin
                    state_next = ENC_DRAIN;
                end else if (accept && remaining == 16'd1) begin
                    // An illegal final bundle with nothing left to write finishes at once.
                    state_next = (illegal && reg_free) ? ENC_DONE : ENC_DRAIN;
                end
            end
            ENC_DRAIN: if (reg_free) state_next = ENC_DONE;
            ENC_DONE:  state_next = ENC_IDLE;
            default:   state_next = ENC_IDLE;
        endcase
    end

    // wptr advances at acceptance; every legal accepted word is written in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            wptr      <= '0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            n_written <= '0;
        end else if (start_load) begin
            remaining <= count;
            wptr      <= {base_addr[W_CPU-1:2], 2'b00};
            n_written <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                remaining <= remaining - 16'd1;
                if (illegal) begin
                    err <= 1'b1;
                end else begin
                    mem_addr  <= wptr;
                    mem_wdata <= word;
                    wptr      <= wptr + 32'd4;
                end
            end
            if (accept && !illegal) begin
                mem_wen <= 1'b1;
            end else if (wr_done) begin
                mem_wen <= 1'b0;
            end
            if (wr_done) begin
                n_written <= n_written + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encode.sv
// Directed bench for inst_encode: hand-computed words, addresses and timing.
module tb_inst_encode;
    import inst_encode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_jaddr;
    logic        mem_wen;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err;
    logic [15:0] n_written;
    enc_state_t  state;

    int checks = 0;
    int errors = 0;

    inst_encode dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct(in_funct),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_jaddr(in_jaddr), .mem_wen(mem_wen), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err(err), .n_written(n_written), .state(state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
        start = 1'b1; base_addr = base; count = cnt;
        tick();
        start = 1'b0; base_addr = 32'hFFFF_FFFF; count = 16'hFFFF;
    endtask

    task automatic set_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh);
        in_op = OP_ZERO; in_funct = f; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = 16'hBEEF; in_jaddr = 26'h3FF_FFFF; in_valid = 1'b1;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm);
        in_op = op; in_funct = 6'h3F; in_rs = rs; in_rt = rt; in_rd = 5'd31; in_shamt = 5'd31;
        in_imm = imm; in_jaddr = 26'h155_5555; in_valid = 1'b1;
    endtask

    task automatic set_j(input logic [5:0] op, input logic [25:0] ja);
        in_op = op; in_funct = 6'h3F; in_rs = 5'd7; in_rt = 5'd7; in_rd = 5'd7; in_shamt = 5'd7;
        in_imm = 16'h1234; in_jaddr = ja; in_valid = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; mem_ready = 1'b0;
        set_r(F_ADD, 1, 2, 3, 0); in_valid = 1'b0;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_mem_wen: got %b exp 0", mem_wen); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {busy, done, err}); end
        checks++; if (n_written !== 16'd0) begin errors++; $display("FAIL rst_n_written: got %0d exp 0", n_written); end
        checks++; if (state !== ENC_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp 0", state); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (state !== ENC_IDLE) begin errors++; $display("FAIL idle_after_rst: got %0d exp 0", state); end
    endtask

    task automatic test_single_add();
        do_start(32'h0040_0000, 16'd1);
        mem_ready = 1'b1;
        set_r(F_ADD, 9, 10, 8, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b exp 1", in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b exp 1", busy); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL add_wen: got %b exp 1", mem_wen); end
        checks++; if (mem_addr !== 32'h0040_0000) begin errors++; $display("FAIL add_addr: got %h exp 00400000", mem_addr); end
        checks++; if (mem_wdata !== 32'h012A_4020) begin errors++; $display("FAIL add_wdata: got %h exp 012a4020", mem_wdata); end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done: got %b exp 1", done); end
        checks++; if (n_written !== 16'd1) begin errors++; $display("FAIL add_n_written: got %0d exp 1", n_written); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL add_wen_low: got %b exp 0", mem_wen); end
        tick();
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL add_done_pulse: got %b exp 00", {done, busy}); end
    endtask

    task automatic test_stream();
        do_start(32'h0001_0000, 16'd3);
        mem_ready = 1'b1;
        set_i(OP_ADDI, 0, 8, 16'd5);
        tick();
        set_r(F_SLL, 7, 9, 8, 2);
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h2008_0005 || mem_addr !== 32'h0001_0000) begin
            errors++; $display("FAIL stream_w0: got wen=%b %h@%h exp 1 20080005@00010000", mem_wen, mem_wdata, mem_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b exp 1", in_ready); end
        tick();
        set_r(F_SYSCAL, 3, 4, 5, 6);
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h0009_4080 || mem_addr !== 32'h0001_0004) begin
            errors++; $display("FAIL stream_w1: got wen=%b %h@%h exp 1 00094080@00010004", mem_wen, mem_wdata, mem_addr); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h0000_000C || mem_addr !== 32'h0001_0008) begin
            errors++; $display("FAIL stream_w2: got wen=%b %h@%h exp 1 0000000c@00010008", mem_wen, mem_wdata, mem_addr); end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b1 || n_written !== 16'd3) begin
            errors++; $display("FAIL stream_done: got done=%b n=%0d exp 1 3", done, n_written); end
        tick();
    endtask

    task automatic test_illegal_funct();
        do_start(32'h0000_4000, 16'd1);
        mem_ready = 1'b1;
        set_r(6'h26, 1, 2, 3, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL illf_done: got %b exp 1", done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illf_err: got %b exp 1", err); end
        checks++; if (mem_wen !== 1'b0 || n_written !== 16'd0) begin
            errors++; $display("FAIL illf_nowrite: got wen=%b n=%0d exp 0 0", mem_wen, n_written); end
        tick();
    endtask

    task automatic test_stall();
        do_start(32'h0000_2003, 16'd2);
        mem_ready = 1'b0;
        set_j(OP_J, 26'h010_0000);
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err_cleared: got %b exp 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready: got %b exp 1", in_ready); end
        tick();
        set_i(OP_ADDI, 0, 8, 16'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h0810_0000 || mem_addr !== 32'h0000_2000) begin
                errors++; $display("FAIL stall_hold%0d: got wen=%b %h@%h exp 1 08100000@00002000", i, mem_wen, mem_wdata, mem_addr); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b exp 0", i, in_ready); end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL stall_release: got ready=%b done=%b exp 1 0", in_ready, done); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h2008_0005 || mem_addr !== 32'h0000_2004 || n_written !== 16'd1) begin
            errors++; $display("FAIL stall_refill: got wen=%b %h@%h n=%0d exp 1 20080005@00002004 1", mem_wen, mem_wdata, mem_addr, n_written); end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b1 || n_written !== 16'd2) begin
            errors++; $display("FAIL stall_done: got done=%b n=%0d exp 1 2", done, n_written); end
        tick();
    endtask

    task automatic test_illegal_op();
        do_start(32'h0000_3000, 16'd2);
        mem_ready = 1'b1;
        set_i(6'h3F, 1, 2, 16'h00FF);
        tick();
        set_i(OP_ADDI, 0, 8, 16'd5);
        @(negedge clk);
        checks++; if (err !== 1'b1 || mem_wen !== 1'b0) begin
            errors++; $display("FAIL illop_err: got err=%b wen=%b exp 1 0", err, mem_wen); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h2008_0005 || mem_addr !== 32'h0000_3000) begin
            errors++; $display("FAIL illop_write: got wen=%b %h@%h exp 1 20080005@00003000", mem_wen, mem_wdata, mem_addr); end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b1 || n_written !== 16'd1 || err !== 1'b1) begin
            errors++; $display("FAIL illop_done: got done=%b n=%0d err=%b exp 1 1 1", done, n_written, err); end
        tick();
    endtask

    task automatic test_count_zero();
        do_start(32'h0000_7000, 16'd0);
        set_i(OP_ADDI, 0, 8, 16'd5);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || state !== ENC_LOAD) begin
            errors++; $display("FAIL cnt0_load: got ready=%b busy=%b st=%0d exp 0 1 1", in_ready, busy, state); end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b0 || mem_wen !== 1'b0) begin
            errors++; $display("FAIL cnt0_drain: got done=%b wen=%b exp 0 0", done, mem_wen); end
        tick();
        // done appears after the second clock edge following the start edge.
        @(negedge clk);
        checks++; if (done !== 1'b1 || mem_wen !== 1'b0 || n_written !== 16'd0) begin
            errors++; $display("FAIL cnt0_done: got done=%b wen=%b n=%0d exp 1 0 0", done, mem_wen, n_written); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_start(32'h0000_5000, 16'd1);
        mem_ready = 1'b0;
        set_r(F_OR, 1, 2, 3, 0);
        tick();
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b exp 1", mem_wen); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_wen !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rmid_outputs: got wen=%b %h@%h exp 0 0@0", mem_wen, mem_wdata, mem_addr); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || state !== ENC_IDLE || n_written !== 16'd0) begin
            errors++; $display("FAIL rmid_ctrl: got busy=%b done=%b ready=%b st=%0d n=%0d exp 0 0 0 0 0", busy, done, in_ready, state, n_written); end
        tick();
        rst_n = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rmid_no_wen: got %b exp 0", mem_wen); end
        tick();
        do_start(32'h0000_6000, 16'd1);
        set_i(OP_ADDI, 0, 8, 16'd5);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_wdata !== 32'h2008_0005 || mem_addr !== 32'h0000_6000) begin
            errors++; $display("FAIL rmid_restart: got wen=%b %h@%h exp 1 20080005@00006000", mem_wen, mem_wdata, mem_addr); end
        tick();
        @(negedge clk);
        checks++; if (done !== 1'b1 || n_written !== 16'd1) begin
            errors++; $display("FAIL rmid_done: got done=%b n=%0d exp 1 1", done, n_written); end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_add();
        test_stream();
        test_illegal_funct();
        test_stall();
        test_illegal_op();
        test_count_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
